// File: rtl/sp_ram_fifo_ctrl.sv
// Circular-buffer FIFO controller owning one single-port 2^AW x DW block RAM.
// Define FIFO_DROP_OLDEST_EN to overwrite the oldest entry on a write while full.
module sp_ram_fifo_ctrl #(
    parameter int AW = 8,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          wr_stb,
    input  logic [DW-1:0] wr_data,
    input  logic          rd_req,
    output logic [DW-1:0] rd_data,
    output logic          rd_valid,
    output logic          rd_busy,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    input  logic          ovf_clr,
    output logic          ram_ce,
    output logic          ram_oce,
    output logic          ram_wre,
    output logic [AW-1:0] ram_ad,
    output logic [DW-1:0] ram_din,
    input  logic [DW-1:0] ram_dout
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_PEND = 2'd1;
    localparam logic [1:0] S_CAPT = 2'd2;

    localparam logic [AW:0] DEPTH = {1'b1, {AW{1'b0}}};

    logic [1:0]    state;
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          wr_go;
    logic          rd_go;
    logic          ovf_hit;
    logic          req_ok;

    assign full    = (count == DEPTH);
    assign empty   = (count == '0);
    assign ovf_hit = wr_stb & full;
    assign rd_busy = (state != S_IDLE) | rd_valid;
    assign ram_oce = 1'b1;

    // A request is taken only in IDLE, outside the rd_valid cycle, with data present.
    assign req_ok = (state == S_IDLE) & rd_req & ~rd_valid & ~empty;

`ifdef FIFO_DROP_OLDEST_EN
    assign wr_go = wr_stb;
`else
    assign wr_go = wr_stb & ~full;
`endif

    // Writes own the port whenever they arrive; a read only goes in a write-free cycle.
    assign rd_go = ~wr_stb & (req_ok | (state == S_PEND));

    always_comb begin
        ram_ce  = wr_go | rd_go;
        ram_wre = wr_go;
        ram_ad  = '0;
        ram_din = '0;
        if (wr_go) begin
            ram_ad  = wr_ptr;
            ram_din = wr_data;
        end else if (rd_go) begin
            ram_ad  = rd_ptr;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_go)
                wr_ptr <= wr_ptr + 1'b1;
`ifdef FIFO_DROP_OLDEST_EN
            if (rd_go || ovf_hit)
                rd_ptr <= rd_ptr + 1'b1;
`else
            if (rd_go)
                rd_ptr <= rd_ptr + 1'b1;
`endif
            // An overwriting write leaves count pinned at DEPTH.
            if (wr_go && !full)
                count <= count + 1'b1;
            else if (rd_go)
                count <= count - 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (req_ok) state <= wr_stb ? S_PEND : S_CAPT;
                S_PEND: if (!wr_stb) state <= S_CAPT;
                S_CAPT: state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // RAM is in bypass mode: dout is valid the cycle after the read edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= (state == S_CAPT);
            if (state == S_CAPT)
                rd_data <= ram_dout;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            overflow <= 1'b0;
        else if (ovf_hit)
            overflow <= 1'b1;
        else if (ovf_clr)
            overflow <= 1'b0;
    end

endmodule

// File: tb/tb_sp_ram_fifo_ctrl.sv
// Directed bench for sp_ram_fifo_ctrl with a queue-based reference model and a RAM model.
module tb_sp_ram_fifo_ctrl;

`ifdef FIFO_DROP_OLDEST_EN
    localparam bit DROP = 1'b1;
`else
    localparam bit DROP = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       wr_stb = 1'b0;
    logic [7:0] wr_data = 8'h00;
    logic       rd_req = 1'b0;
    logic       ovf_clr = 1'b0;
    logic [7:0] rd_data;
    logic       rd_valid, rd_busy, empty, full, overflow;
    logic [8:0] count;
    logic       ram_ce, ram_oce, ram_wre;
    logic [7:0] ram_ad, ram_din;
    logic [7:0] ram_dout;

    int errors = 0;
    int checks = 0;

    sp_ram_fifo_ctrl #(.AW(8), .DW(8)) dut (
        .clk(clk), .reset_n(reset_n), .wr_stb(wr_stb), .wr_data(wr_data),
        .rd_req(rd_req), .rd_data(rd_data), .rd_valid(rd_valid), .rd_busy(rd_busy),
        .count(count), .empty(empty), .full(full), .overflow(overflow), .ovf_clr(ovf_clr),
        .ram_ce(ram_ce), .ram_oce(ram_oce), .ram_wre(ram_wre), .ram_ad(ram_ad),
        .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    // 256x8 single-port RAM: bypass read, normal write (dout unchanged on write)
    logic [7:0] mem [256];
    always @(posedge clk) begin
        if (ram_ce) begin
            if (ram_wre) mem[ram_ad] <= ram_din;
            else         ram_dout <= mem[ram_ad];
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: byte queue, a read waiting for a free port, a byte in flight,
    // and the delivered byte. Pointers are just total writes/reads modulo 256.
    logic [7:0] q[$];
    bit         m_pend, m_fly, m_vld, m_ovf;
    logic [7:0] m_fly_d, m_data;
    logic [7:0] m_wp, m_rp;

    function automatic bit m_busy();
        return m_pend || m_fly || m_vld;
    endfunction
    function automatic bit m_read_now();
        bit acc;
        acc = !m_busy() && rd_req && (q.size() > 0);
        return (m_pend || acc) && !wr_stb;
    endfunction

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            q.delete();
            m_pend = 0; m_fly = 0; m_vld = 0; m_ovf = 0;
            m_fly_d = 0; m_data = 0; m_wp = 0; m_rp = 0;
        end else begin
            bit acc, rdn, fl, nv;
            logic [7:0] nd;
            acc = !m_busy() && rd_req && (q.size() > 0);
            rdn = m_read_now();
            fl  = (q.size() == 256);
            nv  = m_fly;
            nd  = m_fly_d;
            m_fly = 0;
            if (acc) m_pend = 1;
            if (rdn) begin
                m_fly_d = q.pop_front();
                m_fly = 1; m_pend = 0; m_rp++;
            end
            if (wr_stb) begin
                if (!fl) begin
                    q.push_back(wr_data); m_wp++;
                end else if (DROP) begin
                    void'(q.pop_front()); q.push_back(wr_data); m_wp++; m_rp++;
                end
            end
            if (wr_stb && fl) m_ovf = 1;
            else if (ovf_clr) m_ovf = 0;
            m_vld = nv;
            if (nv) m_data = nd;
        end
    end

    // Every cycle out of reset: registered state and the combinational RAM access
    always @(negedge clk) begin
        if (reset_n) begin
            bit rdn, wrn;
            rdn = m_read_now();
            wrn = wr_stb && (q.size() < 256 || DROP);
            chk("count", 32'(count), 32'(q.size()));
            chk("empty", 32'(empty), 32'(q.size() == 0));
            chk("full", 32'(full), 32'(q.size() == 256));
            chk("overflow", 32'(overflow), 32'(m_ovf));
            chk("rd_valid", 32'(rd_valid), 32'(m_vld));
            chk("rd_data", 32'(rd_data), 32'(m_data));
            chk("rd_busy", 32'(rd_busy), 32'(m_busy()));
            chk("ram_ce", 32'(ram_ce), 32'(wrn || rdn));
            chk("ram_wre", 32'(ram_wre), 32'(wrn));
            chk("ram_oce", 32'(ram_oce), 32'd1);
            if (wrn) begin
                chk("ram_ad_wr", 32'(ram_ad), 32'(m_wp));
                chk("ram_din", 32'(ram_din), 32'(wr_data));
            end else if (rdn) begin
                chk("ram_ad_rd", 32'(ram_ad), 32'(m_rp));
            end
        end
    end

    // Inputs change 1 time unit after the active edge.
    task automatic wr(input logic [7:0] d);
        wr_stb = 1'b1; wr_data = d;
        @(posedge clk); #1;
        wr_stb = 1'b0;
    endtask

    task automatic rd(input logic [7:0] exp, input int lat, input bit with_wr, input logic [7:0] wd);
        int n;
        rd_req = 1'b1; wr_stb = with_wr; wr_data = wd;
        @(posedge clk); #1;
        rd_req = 1'b0; wr_stb = 1'b0;
        n = 1;
        while (!rd_valid && n < 10) begin
            @(posedge clk); #1;
            n++;
        end
        chk("rd_seen", 32'(rd_valid), 32'd1);
        chk("rd_latency", 32'(n), 32'(lat));
        chk("rd_byte", 32'(rd_data), 32'(exp));
        chk("busy_in_valid", 32'(rd_busy), 32'd1);
        @(posedge clk); #1;
    endtask

    task automatic idle_no_valid(input int cyc, input string name);
        for (int i = 0; i < cyc; i++) begin
            @(posedge clk); #1;
            chk(name, 32'({rd_valid, rd_busy}), 32'd0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge clk);
        #1;
        chk("rst_count", 32'(count), 32'd0);
        chk("rst_flags", 32'({empty, full, overflow, rd_valid, rd_busy}), 32'b10000);
        chk("rst_ram", 32'({ram_ce, ram_wre, ram_ad, ram_din}), 32'd0);
        chk("rst_rd_data", 32'(rd_data), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // 1: basic ordering, latency 2
        wr(8'h1C); wr(8'h32); wr(8'h21);
        chk("t1_count3", 32'(count), 32'd3);
        rd(8'h1C, 2, 0, 8'h00);
        rd(8'h32, 2, 0, 8'h00);
        rd(8'h21, 2, 0, 8'h00);
        chk("t1_count0", 32'(count), 32'd0);
        chk("t1_empty", 32'(empty), 32'd1);

        // 2: write collides with request; write wins, one extra cycle
        wr(8'hAA);
        rd(8'hAA, 3, 1, 8'h55);
        chk("t2_count", 32'(count), 32'd1);
        rd(8'h55, 2, 0, 8'h00);

        // 3: fill, overflow (set wins over a simultaneous clear), drain
        for (int i = 0; i < 256; i++) wr(8'(i));
        chk("t3_full_pre", 32'({full, overflow}), 32'b10);
        ovf_clr = 1'b1;
        wr(8'h99);
        ovf_clr = 1'b0;
        chk("t3_full", 32'(full), 32'd1);
        chk("t3_overflow", 32'(overflow), 32'd1);
        chk("t3_count", 32'(count), 32'd256);
        for (int i = 0; i < 256; i++) begin
            logic [7:0] e;
            e = DROP ? ((i == 255) ? 8'h99 : 8'(i + 1)) : 8'(i);
            rd(e, 2, 0, 8'h00);
        end
        chk("t3_drained", 32'(empty), 32'd1);
        chk("t3_ovf_sticky", 32'(overflow), 32'd1);
        ovf_clr = 1'b1;
        @(posedge clk); #1;
        ovf_clr = 1'b0;
        chk("t3_ovf_clr", 32'(overflow), 32'd0);

        // 4: request while empty is ignored
        rd_req = 1'b1;
        @(posedge clk); #1;
        rd_req = 1'b0;
        chk("t4_busy", 32'(rd_busy), 32'd0);
        idle_no_valid(4, "t4_no_valid");
        wr(8'h42);
        rd(8'h42, 2, 0, 8'h00);

        // 5: pointer wrap over 300 write/read pairs
        for (int i = 0; i < 300; i++) begin
            wr(8'(i) ^ 8'h5A);
            chk("t5_count", 32'(count), 32'd1);
            rd(8'(i) ^ 8'h5A, 2, 0, 8'h00);
        end
        chk("t5_empty", 32'(empty), 32'd1);

        // 6: reset while a read is pending
        wr(8'h11); wr(8'h22);
        rd_req = 1'b1; wr_stb = 1'b1; wr_data = 8'h33;
        @(posedge clk); #1;
        rd_req = 1'b0; wr_stb = 1'b0;
        chk("t6_pend_busy", 32'(rd_busy), 32'd1);
        reset_n = 1'b0;
        #1;
        chk("t6_rst_count", 32'(count), 32'd0);
        chk("t6_rst_flags", 32'({empty, full, overflow, rd_valid, rd_busy}), 32'b10000);
        chk("t6_rst_ram", 32'({ram_ce, ram_wre, ram_ad, ram_din}), 32'd0);
        chk("t6_rst_rd_data", 32'(rd_data), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
        idle_no_valid(5, "t6_no_valid");
        chk("t6_count", 32'(count), 32'd0);
        wr(8'h77);
        rd(8'h77, 2, 0, 8'h00);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/sp_ram_fifo_ctrl.md
Name: sp_ram_fifo_ctrl

Overview:
- Circular-buffer FIFO controller that owns one external 256x8 single-port block RAM (clk/ce/oce/wre/ad/din/dout RAM, bypass read mode, normal write mode, sync reset tied low).
- Sits directly upstream of that RAM.
- Non-stallable producer side: byte strobes from the PS/2 scancode or UART receiver.
- Consumer side: the CPU I/O port, which requests bytes and receives them with a valid pulse.
- Arbitrates the single RAM port, with writes taking priority.

Parameters:
- AW, 8, RAM address width; depth = 2^AW.
- DW, 8, data width.

Ports:
- clk  in  1  system clock; also drives the RAM clk
- reset_n  in  1  asynchronous active-low reset
- wr_stb  in  1  one-cycle write strobe; producer cannot stall
- wr_data  in  DW  byte to enqueue
- rd_req  in  1  request next byte
- rd_data  out  DW  last byte read; held until the next read completes
- rd_valid  out  1  one-cycle pulse when rd_data is updated
- rd_busy  out  1  read in flight; rd_req is ignored while high
- count  out  AW+1  entries stored, 0..2^AW
- empty  out  1  count==0
- full  out  1  count==2^AW
- overflow  out  1  sticky flag: a write arrived while full
- ovf_clr  in  1  clears overflow
- ram_ce  out  1  RAM clock enable
- ram_oce  out  1  RAM output enable; constant 1
- ram_wre  out  1  RAM write enable
- ram_ad  out  AW  RAM address
- ram_din  out  DW  RAM write data
- ram_dout  in  DW  RAM read data

Behaviour:
- Reset (async, reset_n=0): wr_ptr=0, rd_ptr=0, count=0, state=IDLE, rd_data=0, rd_valid=0, rd_busy=0, overflow=0, empty=1, full=0, ram_ce=0, ram_wre=0, ram_ad=0, ram_din=0.
- Reset mid-read drops the pending read; no rd_valid is issued afterwards.
- RAM outputs are combinational from the current state and inputs, so each access occurs at the same clock edge.
- Write, when wr_stb=1 and not full: ram_ce=1, ram_wre=1, ram_ad=wr_ptr, ram_din=wr_data. At the edge, wr_ptr+1 (wraps modulo 2^AW) and count+1.
- Write when full: RAM is not accessed, data is dropped, overflow<=1.
- Writes are never blocked by reads.
- State machine IDLE -> PEND -> CAPT -> IDLE:
  - IDLE: rd_req=1 and count!=0 goes to PEND. rd_req while empty is ignored and stays IDLE.
  - PEND: if wr_stb=0, issue the read (ram_ce=1, ram_wre=0, ram_ad=rd_ptr; at the edge rd_ptr+1, count-1) and go to CAPT. If wr_stb=1, the write wins and the controller stays in PEND.
  - CAPT: rd_data<=ram_dout, rd_valid<=1 for the following cycle, then IDLE. A write during CAPT is allowed, since write mode leaves dout unchanged.
- Fast path: rd_req in IDLE with wr_stb=0 and count!=0 issues the read in that same cycle and goes straight to CAPT.
- Read latency: rd_req in cycle k with no write conflict gives rd_valid=1 in cycle k+2. Each write conflict adds 1 cycle.
- rd_busy=1 in PEND and CAPT, and in the cycle rd_valid is high. rd_req during rd_busy is ignored.
- count arithmetic: an access modifies count by at most ±1 per cycle; write and read never occur in the same cycle. Exception: drop-oldest mode, see the optional feature.
- overflow: set on a dropped or overwriting write; cleared by ovf_clr; set wins over clear in the same cycle.
- Pointer wrap: 255 -> 0. full/empty are derived from count, never from pointer equality.

Optional Feature:
- Macro: FIFO_DROP_OLDEST_EN.
- When defined, a write while full is performed at wr_ptr (which equals rd_ptr). Both pointers advance, count stays 2^AW, overflow<=1, and the oldest byte is lost.
- If a read is in PEND at that moment, it proceeds later from the advanced rd_ptr.
- When not defined, a write while full is dropped and overflow is set (as described in Behaviour).

Test Plan:
1. Reset, write 0x1C, 0x32, 0x21, then rd_req three times -> rd_data 0x1C, 0x32, 0x21, each with rd_valid 2 cycles after rd_req; count returns to 0; empty=1.
2. rd_req in the same cycle as wr_stb (count=1, stored 0xAA, writing 0x55) -> the write occurs first, rd_valid arrives 3 cycles after rd_req with rd_data=0xAA, and count ends at 1.
3. Fill with 256 writes of i&0xFF, then write 0x99 -> full=1, overflow=1, count=256. Without the macro, reading all bytes returns 0x00..0xFF. With FIFO_DROP_OLDEST_EN, the reads return 0x01..0xFF then 0x99.
4. rd_req while empty -> no RAM access, rd_valid never asserts, rd_busy=0. A later write then rd_req works normally.
5. Pointer wrap: perform 300 write/read pairs -> data matches in order, ram_ad wraps 255->0, count never exceeds 1.
6. Assert reset_n=0 in PEND, then release -> count=0, no rd_valid, all outputs at reset values; overflow is cleared by ovf_clr after being set.
